// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Transmit-side byte queue between the UART register decode and the
//            async transmitter. Buffers up to DEPTH bytes and hands them to the
//            transmitter one at a time via a start/data/busy handshake.
// Ports    : clk_i, rst_ni        - clock, async active-low reset
//            wr_en_i, wr_data_i   - push strobe and byte
//            flush_i              - drop all queued bytes
//            ovf_clr_i            - clear sticky overflow
//            full_o, empty_o      - registered fill flags
//            count_o              - fill level 0..DEPTH
//            overflow_o           - sticky "a push was dropped"
//            idle_o               - queue empty, FSM idle, transmitter idle
//            tx_start_o, tx_data_o- one-cycle start pulse and held byte
//            tx_busy_i            - transmitter busy
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     flush_i,
  input  logic                     ovf_clr_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     idle_o,
  output logic                     tx_start_o,
  output logic [7:0]               tx_data_o,
  input  logic                     tx_busy_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
  localparam logic [TW-1:0] C_TMO_MAX = TW'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          ovf_q, ovf_d;
  state_t        state_q;
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_inc;
  logic          tx_start_q;
  logic [7:0]    tx_data_q;

  logic push;
  logic drop;
  logic pop;

  // Flush outranks both push and pop. A full FIFO drops the push even if a pop
  // frees a slot in the same cycle, since full_q is the registered view.
  always_comb begin
    push = wr_en_i & ~flush_i & ~full_q;
    drop = wr_en_i & ~flush_i &  full_q;
    pop  = (state_q == ST_IDLE) & ~empty_q & ~tx_busy_i & ~flush_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Set wins over clear.
    if (drop)           ovf_d = 1'b1;
    else if (ovf_clr_i) ovf_d = 1'b0;
    else                ovf_d = ovf_q;

    tmo_inc = tmo_q + TW'(1);
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == C_DEPTH);
      empty_q  <= (count_d == '0);
      ovf_q    <= ovf_d;
    end
  end

  // Handshake FSM. The pop happens on the IDLE->START edge; a byte whose
  // transmitter never raises busy is abandoned after BUSY_TIMEOUT cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q    <= ST_START;
            tx_start_q <= 1'b1;
            tx_data_q  <= mem[rd_ptr_q];
          end
        end
        ST_START: begin
          tx_start_q <= 1'b0;
          tmo_q      <= '0;
          state_q    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy_i) begin
            state_q <= ST_WAIT_DONE;
          end else begin
            tmo_q <= tmo_inc;
            if (tmo_inc == C_TMO_MAX) state_q <= ST_IDLE;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy_i) state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          tx_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign idle_o     = empty_q & (state_q == ST_IDLE) & ~tx_busy_i;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed self-checking bench for uart_tx_fifo with a simple
//            transmitter model (busy rises the cycle after start, stays high
//            busy_len cycles) and a monitor that logs every started byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       flush_i = 1'b0;
  logic       ovf_clr_i = 1'b0;
  logic       full_o, empty_o, overflow_o, idle_o, tx_start_o;
  logic [4:0] count_o;
  logic [7:0] tx_data_o;
  logic       tx_busy_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Transmitter model controls (written only by the stimulus block).
  bit model_en = 1'b1;
  bit stall    = 1'b0;
  int busy_len = 10;
  bit track    = 1'b0;

  logic busy_m = 1'b0;
  int   busy_left = 0;
  logic [7:0] out_q[$];
  int   max_cnt = 0;

  uart_tx_fifo #(.DEPTH(16), .BUSY_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .flush_i(flush_i), .ovf_clr_i(ovf_clr_i), .full_o(full_o), .empty_o(empty_o),
    .count_o(count_o), .overflow_o(overflow_o), .idle_o(idle_o),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_busy_i(tx_busy_i)
  );

  always #5 clk_i = ~clk_i;

  assign tx_busy_i = busy_m | stall;

  always @(posedge clk_i) begin
    if (model_en && tx_start_o) begin
      busy_m    <= 1'b1;
      busy_left <= busy_len;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      busy_m    <= 1'b0;
      busy_left <= 0;
    end
  end

  always @(negedge clk_i) begin
    if (tx_start_o) out_q.push_back(tx_data_o);
    if (!track) max_cnt = 0;
    else if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en_i = 1'b1;
    wr_data_i = b;
    tick(1);
    wr_en_i = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    for (int n = 0; n < bound; n++) begin
      if (idle_o) break;
      tick(1);
    end
    chk(tag, {31'd0, idle_o}, 32'd1);
  endtask

  initial begin
    int base;

    // ---------------- reset values ----------------
    #12;
    chk("rst_full",  {31'd0, full_o},     32'd0);
    chk("rst_empty", {31'd0, empty_o},    32'd1);
    chk("rst_count", {27'd0, count_o},    32'd0);
    chk("rst_ovf",   {31'd0, overflow_o}, 32'd0);
    chk("rst_start", {31'd0, tx_start_o}, 32'd0);
    chk("rst_data",  {24'd0, tx_data_o},  32'd0);
    chk("rst_idle",  {31'd0, idle_o},     32'd1);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    tick(2);

    // ---------------- 1: single byte latency ----------------
    base = out_q.size();
    push(8'h41);
    chk("t1_start_n1", {31'd0, tx_start_o}, 32'd0);
    chk("t1_count_n1", {27'd0, count_o},    32'd1);
    tick(1);
    chk("t1_start_n2", {31'd0, tx_start_o}, 32'd1);
    chk("t1_data_n2",  {24'd0, tx_data_o},  32'h41);
    chk("t1_count_n2", {27'd0, count_o},    32'd0);
    tick(1);
    chk("t1_start_n3", {31'd0, tx_start_o}, 32'd0);
    wait_idle(40, "t1_idle");
    chk("t1_nstarts", out_q.size() - base, 32'd1);
    chk("t1_count_end", {27'd0, count_o}, 32'd0);

    // ---------------- 2: burst to full, overflow, ordered drain ----------------
    base = out_q.size();
    stall = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_full",  {31'd0, full_o},  32'd1);
    chk("t2_count", {27'd0, count_o}, 32'd16);
    chk("t2_ovf_before", {31'd0, overflow_o}, 32'd0);
    push(8'hFF);
    chk("t2_ovf",    {31'd0, overflow_o}, 32'd1);
    chk("t2_count2", {27'd0, count_o},    32'd16);
    stall = 1'b0;
    wait_idle(400, "t2_idle");
    chk("t2_nstarts", out_q.size() - base, 32'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t2_byte%0d", i), {24'd0, out_q[base + i]}, i);
    ovf_clr_i = 1'b1;
    tick(1);
    ovf_clr_i = 1'b0;
    chk("t2_ovf_clr", {31'd0, overflow_o}, 32'd0);

    // ---------------- 3: push+pop while full, clear vs set ----------------
    base = out_q.size();
    stall = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    chk("t3_full", {31'd0, full_o}, 32'd1);
    stall = 1'b0;
    push(8'hAA);
    chk("t3_count15", {27'd0, count_o},    32'd15);
    chk("t3_ovf",     {31'd0, overflow_o}, 32'd1);
    chk("t3_full0",   {31'd0, full_o},     32'd0);
    chk("t3_start",   {31'd0, tx_start_o}, 32'd1);
    chk("t3_data",    {24'd0, tx_data_o},  32'h20);
    push(8'h30);
    chk("t3_refull",  {31'd0, full_o}, 32'd1);
    wr_en_i = 1'b1; wr_data_i = 8'hBB; ovf_clr_i = 1'b1;
    tick(1);
    wr_en_i = 1'b0; ovf_clr_i = 1'b0;
    chk("t3_set_wins", {31'd0, overflow_o}, 32'd1);
    ovf_clr_i = 1'b1;
    tick(1);
    ovf_clr_i = 1'b0;
    chk("t3_clr", {31'd0, overflow_o}, 32'd0);
    wait_idle(500, "t3_idle");
    chk("t3_nstarts", out_q.size() - base, 32'd17);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t3_byte%0d", i), {24'd0, out_q[base + i]}, 32'h20 + i);
    chk("t3_byte16", {24'd0, out_q[base + 16]}, 32'h30);

    // ---------------- 4: wrap-around with interleaved pops ----------------
    base = out_q.size();
    busy_len = 3;
    track = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push(8'h60 + 8'(i));
      if (i % 5 == 4) tick(25);
    end
    wait_idle(400, "t4_idle");
    track = 1'b0;
    chk("t4_nstarts", out_q.size() - base, 32'd40);
    for (int i = 0; i < 40; i++)
      chk($sformatf("t4_byte%0d", i), {24'd0, out_q[base + i]}, 32'h60 + i);
    chk("t4_maxcnt_le16", {31'd0, (max_cnt <= 16)}, 32'd1);
    chk("t4_ovf", {31'd0, overflow_o}, 32'd0);

    // ---------------- 5: flush with byte in flight and same-cycle push ----------------
    base = out_q.size();
    busy_len = 10;
    stall = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h70 + 8'(i));
    stall = 1'b0;
    tick(1);
    chk("t5_start", {31'd0, tx_start_o}, 32'd1);
    chk("t5_data",  {24'd0, tx_data_o},  32'h70);
    chk("t5_count", {27'd0, count_o},    32'd5);
    flush_i = 1'b1; wr_en_i = 1'b1; wr_data_i = 8'h55;
    tick(1);
    flush_i = 1'b0; wr_en_i = 1'b0;
    chk("t5_count0", {27'd0, count_o},    32'd0);
    chk("t5_empty",  {31'd0, empty_o},    32'd1);
    chk("t5_ovf",    {31'd0, overflow_o}, 32'd0);
    wait_idle(100, "t5_idle");
    tick(5);
    chk("t5_nstarts", out_q.size() - base, 32'd1);
    chk("t5_byte",    {24'd0, out_q[base]}, 32'h70);
    chk("t5_count_end", {27'd0, count_o}, 32'd0);

    // ---------------- 6: busy timeout, then async reset in WAIT_DONE ----------------
    base = out_q.size();
    model_en = 1'b0;
    push(8'h81);
    push(8'h82);
    chk("t6_start1", {31'd0, tx_start_o}, 32'd1);
    chk("t6_data1",  {24'd0, tx_data_o},  32'h81);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk($sformatf("t6_nostart%0d", k), {31'd0, tx_start_o}, 32'd0);
    end
    tick(1);
    chk("t6_start2", {31'd0, tx_start_o}, 32'd1);
    chk("t6_data2",  {24'd0, tx_data_o},  32'h82);
    wait_idle(20, "t6_idle_tmo");
    model_en = 1'b1;
    push(8'h91);
    tick(1);
    chk("t6_start3", {31'd0, tx_start_o}, 32'd1);
    push(8'h92);
    tick(1);
    chk("t6_pre_count", {27'd0, count_o},   32'd1);
    chk("t6_pre_data",  {24'd0, tx_data_o}, 32'h91);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_start", {31'd0, tx_start_o}, 32'd0);
    chk("t6_rst_data",  {24'd0, tx_data_o},  32'd0);
    chk("t6_rst_count", {27'd0, count_o},    32'd0);
    chk("t6_rst_empty", {31'd0, empty_o},    32'd1);
    chk("t6_rst_full",  {31'd0, full_o},     32'd0);
    chk("t6_rst_ovf",   {31'd0, overflow_o}, 32'd0);
    chk("t6_rst_idle_busy", {31'd0, idle_o}, 32'd0);
    tick(1);
    rst_ni = 1'b1;
    wait_idle(30, "t6_idle_after_rst");
    tick(5);
    chk("t6_nstarts", out_q.size() - base, 32'd3);
    chk("t6_count_end", {27'd0, count_o}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
